// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Opcode and status-flag definitions shared by the ALU datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam logic [2:0] OP_CLR = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_NOT = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_SHL = 3'd7;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_core
// Description : Combinational eight-operation ALU producing result and {V,N,Z,C}.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shl;
  logic             w_carry;
  logic             w_ovf;

  always_comb begin
    w_b_eff = (op == OP_SUB) ? ~b : b;
    w_sum   = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, ci};
    // The extra top bit catches the last bit shifted out; zero for shift 0.
    w_shl   = {1'b0, a} << b[SHW-1:0];
    result  = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        result  = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_NOT: result = ~a;
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SHL: begin
        result  = w_shl[WIDTH-1:0];
        w_carry = w_shl[WIDTH];
      end
      default: result = '0;
    endcase
    flags         = 4'b0000;
    flags[FLAG_C] = w_carry;
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_N] = result[WIDTH-1];
    flags[FLAG_V] = w_ovf;
  end

endmodule
`default_nettype wire

// File: rtl/pipelined_alu.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_alu
// Description : Two-stage valid/ready accumulator ALU with carry chaining.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] din,
  input  logic             cin,
  input  logic             cin_sel,
  input  logic [2:0]       alu_select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [3:0]       flags
);

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic             r_s1_cin;
  logic             r_s1_cin_sel;
  logic [2:0]       r_s1_op;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_alu_out;
  logic [3:0]       r_flags;
  logic             r_c_q;

  logic             w_s1_adv;
  logic             w_in_fire;
  logic             w_ci;
  logic [WIDTH-1:0] w_res;
  logic [3:0]       w_flags;

  assign w_s1_adv  = r_s1_valid & (~r_out_valid | out_ready);
  assign in_ready  = rst & (~r_s1_valid | w_s1_adv);
  assign w_in_fire = in_valid & in_ready;
  // c_q always belongs to the previous beat because results load strictly in order.
  assign w_ci      = r_s1_cin_sel ? r_c_q : r_s1_cin;

  alu_core #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_alu_core (
    .a      (r_s1_a),
    .b      (r_s1_b),
    .ci     (w_ci),
    .op     (r_s1_op),
    .result (w_res),
    .flags  (w_flags)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_a       <= '0;
      r_s1_b       <= '0;
      r_s1_cin     <= 1'b0;
      r_s1_cin_sel <= 1'b0;
      r_s1_op      <= OP_CLR;
      r_out_valid  <= 1'b0;
      r_alu_out    <= '0;
      r_flags      <= 4'b0000;
      r_c_q        <= 1'b0;
    end else begin
      if (w_in_fire) begin
        r_s1_valid   <= 1'b1;
        r_s1_a       <= acc;
        r_s1_b       <= din;
        r_s1_cin     <= cin;
        r_s1_cin_sel <= cin_sel;
        r_s1_op      <= alu_select;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end

      if (w_s1_adv) begin
        r_out_valid <= 1'b1;
        r_alu_out   <= w_res;
        r_flags     <= w_flags;
        r_c_q       <= w_flags[FLAG_C];
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign alu_out   = r_alu_out;
  assign flags     = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_alu
// Description : Self-checking bench for pipelined_alu with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] acc = '0;
  logic [31:0] din = '0;
  logic        cin = 1'b0;
  logic        cin_sel = 1'b0;
  logic [2:0]  alu_select = 3'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] alu_out;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipelined_alu #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .acc        (acc),
    .din        (din),
    .cin        (cin),
    .cin_sel    (cin_sel),
    .alu_select (alu_select),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_out    (alu_out),
    .flags      (flags)
  );

  // Reference: returns {V,N,Z,C,result} computed with integer arithmetic.
  function automatic logic [35:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic ci, input logic [2:0] op);
    logic [31:0] r;
    logic c, v;
    longint sa, sb, st;
    longint unsigned ua, ub, u;
    int sh;
    r = '0; c = 1'b0; v = 1'b0;
    sa = $signed(a); sb = $signed(b);
    ua = a; ub = b;
    case (op)
      3'd1: begin
        u  = ua + ub + 64'(ci);
        r  = u[31:0];
        c  = u[32];
        st = sa + sb + 64'(ci);
        v  = (st > 64'sd2147483647) || (st < -64'sd2147483648);
      end
      3'd2: begin
        r  = a - b - {31'b0, ~ci};
        c  = (ua + 64'(ci)) > ub;
        st = sa - sb - (ci ? 64'sd0 : 64'sd1);
        v  = (st > 64'sd2147483647) || (st < -64'sd2147483648);
      end
      3'd3: r = ~a;
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = a ^ b;
      3'd7: begin
        sh = int'(b[4:0]);
        r  = a << sh;
        c  = (sh == 0) ? 1'b0 : a[32-sh];
      end
      default: r = '0;
    endcase
    return {v, r[31], (r == 32'd0), c, r};
  endfunction

  task automatic drive(input logic [31:0] a_i, input logic [31:0] b_i, input logic cin_i,
                       input logic sel_i, input logic [2:0] op_i);
    in_valid   = 1'b1;
    acc        = a_i;
    din        = b_i;
    cin        = cin_i;
    cin_sel    = sel_i;
    alu_select = op_i;
  endtask

  task automatic do_op(input logic [31:0] a_i, input logic [31:0] b_i, input logic cin_i,
                       input logic sel_i, input logic [2:0] op_i,
                       output logic ov, output logic [31:0] res, output logic [3:0] flg);
    drive(a_i, b_i, cin_i, sel_i, op_i);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    ov = out_valid; res = alu_out; flg = flags;
  endtask

  task automatic idle(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, in_ready, alu_out, flags} !== 38'd0) begin
      errors++;
      $display("FAIL reset_state: got v=%b rdy=%b out=%h fl=%b expected all zero",
               out_valid, in_ready, alu_out, flags);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b expected 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add_carry;
    drive(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, OP_ADD);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_latency_early: got out_valid=%b expected 0", out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if ({out_valid, alu_out, flags} !== {1'b1, 32'h0, 4'b0011}) begin
      errors++;
      $display("FAIL add_carry: got v=%b out=%h fl=%b expected v=1 out=00000000 fl=0011",
               out_valid, alu_out, flags);
    end
  endtask

  task automatic test_chain;
    logic ov; logic [31:0] res; logic [3:0] flg;
    do_op(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, OP_ADD, ov, res, flg);
    do_op(32'h0, 32'h0, 1'b0, 1'b1, OP_ADD, ov, res, flg);
    checks++;
    if ({ov, res, flg} !== {1'b1, 32'h1, 4'b0000}) begin
      errors++;
      $display("FAIL chain_add: got v=%b out=%h fl=%b expected v=1 out=00000001 fl=0000",
               ov, res, flg);
    end
  endtask

  task automatic test_sub_ovf;
    logic ov; logic [31:0] res; logic [3:0] flg;
    do_op(32'd5, 32'd7, 1'b1, 1'b0, OP_SUB, ov, res, flg);
    checks++;
    if ({ov, res, flg} !== {1'b1, 32'hFFFFFFFE, 4'b0100}) begin
      errors++;
      $display("FAIL sub_borrow: got v=%b out=%h fl=%b expected out=fffffffe fl=0100", ov, res, flg);
    end
    do_op(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, OP_ADD, ov, res, flg);
    checks++;
    if ({ov, res, flg} !== {1'b1, 32'h80000000, 4'b1100}) begin
      errors++;
      $display("FAIL add_overflow: got v=%b out=%h fl=%b expected out=80000000 fl=1100", ov, res, flg);
    end
  endtask

  task automatic test_logic_ops;
    logic ov; logic [31:0] res; logic [3:0] flg;
    logic [2:0]  ops [6];
    logic [31:0] bs  [6];
    logic [35:0] exp [6];
    ops = '{OP_NOT, OP_AND, OP_XOR, OP_SHL, OP_OR, OP_CLR};
    bs  = '{32'hACA6ACA6, 32'hACA6ACA6, 32'hACA6ACA6, 32'hACA6ACA4, 32'hACA6ACA6, 32'hACA6ACA6};
    exp = '{{4'b0000, 32'h53595249}, {4'b0100, 32'hACA6ACA6}, {4'b0000, 32'h00000110},
            {4'b0100, 32'hCA6ADB60}, {4'b0100, 32'hACA6ADB6}, {4'b0010, 32'h00000000}};
    for (int i = 0; i < 6; i++) begin
      do_op(32'hACA6ADB6, bs[i], 1'b1, 1'b0, ops[i], ov, res, flg);
      checks++;
      if ({ov, flg, res} !== {1'b1, exp[i]}) begin
        errors++;
        $display("FAIL logic_op%0d: got v=%b fl=%b out=%h expected fl=%b out=%h",
                 ops[i], ov, flg, res, exp[i][35:32], exp[i][31:0]);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] av [3];
    logic [35:0] e;
    int accepted;
    av = '{32'h11111111, 32'h22222222, 32'h33333333};
    idle(2);
    out_ready = 1'b0;
    accepted  = 0;
    drive(av[0], 32'h5, 1'b0, 1'b0, OP_ADD);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (in_valid && in_ready) accepted++;
      @(posedge clk); #1;
      if (accepted < 3) drive(av[accepted], 32'h5, 1'b0, 1'b0, OP_ADD);
    end
    @(negedge clk);
    checks++;
    if (accepted !== 2 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept: got accepted=%0d in_ready=%b expected 2 and 0", accepted, in_ready);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      e = ref_alu(av[i], 32'h5, 1'b0, OP_ADD);
      checks++;
      if ({out_valid, flags, alu_out} !== {1'b1, e}) begin
        errors++;
        $display("FAIL bp_drain%0d: got v=%b fl=%b out=%h expected v=1 fl=%b out=%h",
                 i, out_valid, flags, alu_out, e[35:32], e[31:0]);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_dup: got out_valid=%b expected 0", out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_inflight;
    logic ov; logic [31:0] res; logic [3:0] flg;
    idle(2);
    out_ready = 1'b0;
    drive(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, OP_ADD);
    @(posedge clk); #1;
    drive(32'h12345678, 32'h1, 1'b0, 1'b0, OP_ADD);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_ready_low: got %b expected 0", in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b1;
    checks++;
    if ({out_valid, alu_out, flags} !== 37'd0) begin
      errors++;
      $display("FAIL rst_flush: got v=%b out=%h fl=%b expected all zero", out_valid, alu_out, flags);
    end
    do_op(32'h0, 32'h0, 1'b1, 1'b1, OP_ADD, ov, res, flg);
    checks++;
    if ({ov, res, flg} !== {1'b1, 32'h0, 4'b0010}) begin
      errors++;
      $display("FAIL rst_chain_cq: got v=%b out=%h fl=%b expected v=1 out=00000000 fl=0010",
               ov, res, flg);
    end
  endtask

  task automatic test_random;
    logic [35:0] q[$];
    logic [35:0] e;
    logic        mc;
    logic        ci;
    mc = 1'b0;
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst       = ($urandom_range(0, 79) != 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      acc       = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
      din       = ($urandom_range(0, 3) == 0) ? 32'h00000001 : $urandom;
      cin       = 1'($urandom_range(0, 1));
      cin_sel   = 1'($urandom_range(0, 1));
      alu_select = 3'($urandom_range(0, 7));
      @(negedge clk);
      if (!rst) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL rnd_rst_ready: cycle %0d got %b expected 0", cyc, in_ready);
        end
        q.delete();
        mc = 1'b0;
      end else begin
        checks++;
        if (in_ready !== ((q.size() < 2) || out_ready)) begin
          errors++;
          $display("FAIL rnd_ready: cycle %0d got %b expected %b", cyc, in_ready,
                   ((q.size() < 2) || out_ready));
        end
        if (out_valid) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL rnd_spurious: cycle %0d got out_valid=1 expected 0", cyc);
          end else if ({flags, alu_out} !== q[0]) begin
            errors++;
            $display("FAIL rnd_data: cycle %0d got fl=%b out=%h expected fl=%b out=%h",
                     cyc, flags, alu_out, q[0][35:32], q[0][31:0]);
          end
          if (out_ready && q.size() > 0) void'(q.pop_front());
        end
        if (in_valid && in_ready) begin
          ci = cin_sel ? mc : cin;
          e  = ref_alu(acc, din, ci, alu_select);
          mc = e[32];
          q.push_back(e);
        end
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    idle(3);
  endtask

  initial begin
    test_reset;
    test_add_carry;
    test_chain;
    test_sub_ovf;
    test_logic_ops;
    test_backpressure;
    test_reset_inflight;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipelined_alu.md
# pipelined_alu

Parametrised two-stage accumulator ALU with valid/ready handshakes on both sides. It is the next generation of the datapath ALU and sits between the operand fetch and accumulator write-back stages of the core. It adds to the single-cycle ALU: configurable width, an eight-operation set, subtraction, shifts, a full status-flag set, carry chaining for multi-word arithmetic, and backpressure.

## Interface
- WIDTH, 32, operand and result width; must be ≥ 4 and a power of 2
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override)
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  synchronous, active-low reset
- in_valid  in  1  operand beat present
- in_ready  out  1  block accepts the beat this cycle
- acc  in  WIDTH  operand A
- din  in  WIDTH  operand B
- cin  in  1  carry-in, used when cin_sel=0
- cin_sel  in  1  1 = take carry-in from the internal carry register (chained op)
- alu_select  in  3  opcode
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts the result
- alu_out  out  WIDTH  result
- flags  out  4  {V,N,Z,C}: overflow, negative, zero, carry

## Operation
- Opcodes:
  - 0 CLR: result 0.
  - 1 ADD: A+B+ci.
  - 2 SUB: A+~B+ci. ci=1 means no borrow; C=1 means no borrow out.
  - 3 NOT: ~A.
  - 4 AND.
  - 5 OR.
  - 6 XOR.
  - 7 SHL: A<<B[SHW-1:0].
- ci = cin_sel ? c_q : cin. Here c_q is the carry flag of the most recently computed result, which is exactly the previous accepted beat in order.
- Arithmetic is done at WIDTH+1 bits. C = bit WIDTH.
- V for ADD and SUB is signed two's-complement overflow of A and the effective B operand. V=0 for every other opcode.
- N = result[WIDTH-1]. Z = (result==0).
- C=0 for CLR and all logic ops.
- For SHL, C = last bit shifted out. If the shift amount is 0, C=0.
- c_q is updated only when a result loads into the output register.

## Timing
- Stage 1 registers the operands, opcode and carry select on an input handshake (in_valid & in_ready).
- Stage 2 computes and loads alu_out, flags and c_q when stage 1 advances.
- Latency: a beat accepted at edge k gives out_valid=1 after edge k+1. Throughput is one beat per cycle when out_ready=1.
- Advance rule: s1_adv = s1_valid & (~out_valid | out_ready).
- in_ready = rst & (~s1_valid | s1_adv). This is combinational from out_ready; there is no combinational path from in_valid.
- Output holds stable while out_valid & ~out_ready. At most 2 beats are held in flight.
- A simultaneous output pop and input push in the same cycle is lossless, with no bubble.
- While rst=0 at an edge:
  - out_valid=0, s1_valid=0.
  - alu_out=0, flags=0, c_q=0.
  - in_ready is held 0.
- A reset mid-operation discards in-flight beats, with no partial output. The first beat after reset sees c_q=0.

## Structure
- Package alu_pkg:
  - opcode localparams OP_CLR..OP_SHL
  - flag bit indices FLAG_C=0, FLAG_Z=1, FLAG_N=2, FLAG_V=3
- Sub-module alu_core (parametrised by WIDTH): purely combinational; takes A, B, ci and opcode, returns result and {V,N,Z,C}.
- pipelined_alu holds only the stage registers, handshake logic and c_q.

## Test plan
All scenarios use WIDTH=32.
- ADD A=0xFFFFFFFF, B=0x1, cin=0 -> alu_out=0x0, C=1, Z=1, N=0, V=0. out_valid appears exactly 2 edges after acceptance.
- Chain: ADD 0xFFFFFFFF+0x1 (cin_sel=0), then ADD 0x0+0x0 with cin_sel=1 -> second result is 0x1, C=0.
- SUB A=5, B=7, cin=1 -> 0xFFFFFFFE, C=0, N=1. ADD 0x7FFFFFFF+0x1 -> 0x80000000, V=1, N=1.
- Ops on A=0xACA6ADB6, B=0xACA6ACA6:
  - NOT -> 0x53595249
  - AND -> 0xACA6ACA6
  - XOR -> 0x00000110
  - SHL with B[4:0]=4 -> 0xCA6ADB60, C=0
- Backpressure: hold out_ready=0 and offer 3 beats back-to-back.
  - Exactly 2 beats are accepted, then in_ready=0.
  - Release out_ready: results emerge in order, one per cycle, with no loss or duplication.
- Reset with 2 beats in flight (rst=0 for one edge):
  - Next cycle: out_valid=0, alu_out=0, flags=0.
  - A following chained ADD 0+0 with cin_sel=1 gives 0x0.
